fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_fetch_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues one word fetch at a time, holds the
// fetched word toward decode, and handles redirects, debug halt and failures.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        debug_halt,
    input  logic        debug_fail,
    input  logic        resume,
    output logic        halted,
    output logic        failed,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] TIMEOUT_W = 32'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD,
        S_DRAIN,
        S_HALT,
        S_FAIL
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic [31:0] count_q, count_d;
    logic [31:0] wd_q, wd_d;
    logic        halt_pend_q, halt_pend_d;
    logic        req_q, req_d;
    logic        valid_q, valid_d;
    logic        halted_q, halted_d;
    logic        failed_q, failed_d;

    logic        redir_bad;
    logic        transfer;
    logic        timeout;
    logic        halt_now;
    logic [31:0] wd_next;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        addr_d      = addr_q;
        instr_d     = instr_q;
        instr_pc_d  = instr_pc_q;
        count_d     = count_q;
        wd_d        = wd_q;
        halt_pend_d = halt_pend_q;

        redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
        transfer  = valid_q && instr_ready && !redirect_valid;
        wd_next   = wd_q + 32'd1;
        timeout   = req_q && !imem_ack && (wd_next == TIMEOUT_W);
        halt_now  = halt_pend_q || debug_halt;

        if (state_q == S_IDLE) begin
            state_d = S_FETCH;
            addr_d  = pc_q;
            wd_d    = '0;
        end else if (state_q == S_FAIL) begin
            state_d = S_FAIL;
        end else if (debug_fail || redir_bad || timeout) begin
            state_d = S_FAIL;
        end else begin
            if (redirect_valid) begin
                pc_d = redirect_pc;
            end
            if (req_q && !imem_ack) begin
                wd_d = wd_next;
            end
            case (state_q)
                S_FETCH: begin
                    if (imem_ack) begin
                        if (halt_now) begin
                            state_d     = S_HALT;
                            halt_pend_d = 1'b0;
                        end else if (redirect_valid) begin
                            state_d = S_FETCH;
                            addr_d  = pc_d;
                            wd_d    = '0;
                        end else begin
                            state_d    = S_HOLD;
                            instr_d    = imem_rdata;
                            instr_pc_d = pc_q;
                        end
                    end else if (halt_now || redirect_valid) begin
                        state_d     = S_DRAIN;
                        halt_pend_d = halt_now;
                    end
                end
                S_HOLD: begin
                    if (transfer) begin
                        pc_d    = pc_q + 32'd4;
                        count_d = count_q + 32'd1;
                    end
                    if (halt_now) begin
                        state_d     = S_HALT;
                        halt_pend_d = 1'b0;
                    end else if (redirect_valid || transfer) begin
                        state_d = S_FETCH;
                        addr_d  = pc_d;
                        wd_d    = '0;
                    end
                end
                S_DRAIN: begin
                    // The outstanding request keeps its address; only pc moves.
                    halt_pend_d = halt_now;
                    if (imem_ack) begin
                        if (halt_now) begin
                            state_d     = S_HALT;
                            halt_pend_d = 1'b0;
                        end else begin
                            state_d = S_FETCH;
                            addr_d  = pc_d;
                            wd_d    = '0;
                        end
                    end
                end
                S_HALT: begin
                    if (resume) begin
                        state_d = S_FETCH;
                        addr_d  = pc_d;
                        wd_d    = '0;
                    end
                end
                default: state_d = S_FAIL;
            endcase
        end

        req_d    = (state_d == S_FETCH) || (state_d == S_DRAIN);
        valid_d  = (state_d == S_HOLD);
        halted_d = (state_d == S_HALT);
        failed_d = (state_d == S_FAIL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            addr_q      <= RESET_PC;
            instr_q     <= '0;
            instr_pc_q  <= '0;
            count_q     <= '0;
            wd_q        <= '0;
            halt_pend_q <= 1'b0;
            req_q       <= 1'b0;
            valid_q     <= 1'b0;
            halted_q    <= 1'b0;
            failed_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            addr_q      <= addr_d;
            instr_q     <= instr_d;
            instr_pc_q  <= instr_pc_d;
            count_q     <= count_d;
            wd_q        <= wd_d;
            halt_pend_q <= halt_pend_d;
            req_q       <= req_d;
            valid_q     <= valid_d;
            halted_q    <= halted_d;
            failed_q    <= failed_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign halted      = halted_q;
    assign failed      = failed_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: fetch/transfer, stall, redirect/drain,
// debug halt/resume, watchdog, misaligned redirect, debug fail and reset.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        debug_halt;
    logic        debug_fail;
    logic        resume;
    logic        halted;
    logic        failed;
    logic [31:0] fetch_count;

    int assert_count = 0;
    int fail_count   = 0;

    fetch_ctrl #(
        .RESET_PC(32'h0000_0000),
        .TIMEOUT (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_ready   (instr_ready),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .debug_halt    (debug_halt),
        .debug_fail    (debug_fail),
        .resume        (resume),
        .halted        (halted),
        .failed        (failed),
        .fetch_count   (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic ack, input logic [31:0] rdata,
                                 input logic ready, input logic redir_v,
                                 input logic [31:0] redir_pc, input logic halt,
                                 input logic fail, input logic res);
        imem_ack       = ack;
        imem_rdata     = rdata;
        instr_ready    = ready;
        redirect_valid = redir_v;
        redirect_pc    = redir_pc;
        debug_halt     = halt;
        debug_fail     = fail;
        resume         = res;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, " imem_req"}, {31'd0, imem_req}, 32'd0);
        checkOutput({tag, " imem_addr"}, imem_addr, 32'h0);
        checkOutput({tag, " instr_valid"}, {31'd0, instr_valid}, 32'd0);
        checkOutput({tag, " instr"}, instr, 32'h0);
        checkOutput({tag, " instr_pc"}, instr_pc, 32'h0);
        checkOutput({tag, " halted"}, {31'd0, halted}, 32'd0);
        checkOutput({tag, " failed"}, {31'd0, failed}, 32'd0);
        checkOutput({tag, " fetch_count"}, fetch_count, 32'd0);
    endtask

    initial begin
        applyStimulus(0, 32'h0, 0, 0, 32'h0, 0, 0, 0);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        checkReset("reset");
        tick();
        tick();
        rst_n = 1'b1;
        checkOutput("idle req", {31'd0, imem_req}, 32'd0);

        // Basic fetch: ack two cycles after request, decode ready
        tick();
        checkOutput("fetch0 req", {31'd0, imem_req}, 32'd1);
        checkOutput("fetch0 addr", imem_addr, 32'h0);
        tick();
        checkOutput("fetch0 wait req", {31'd0, imem_req}, 32'd1);
        applyStimulus(1, 32'h1300_0000, 1, 0, 32'h0, 0, 0, 0);
        tick();
        applyStimulus(0, 32'h0, 1, 0, 32'h0, 0, 0, 0);
        checkOutput("hold0 valid", {31'd0, instr_valid}, 32'd1);
        checkOutput("hold0 instr", instr, 32'h1300_0000);
        checkOutput("hold0 pc", instr_pc, 32'h0);
        checkOutput("hold0 req", {31'd0, imem_req}, 32'd0);
        tick();
        checkOutput("fetch1 addr", imem_addr, 32'h4);
        checkOutput("fetch1 req", {31'd0, imem_req}, 32'd1);
        checkOutput("fetch1 count", fetch_count, 32'd1);
        checkOutput("fetch1 valid", {31'd0, instr_valid}, 32'd0);

        // Stall in HOLD for five cycles
        applyStimulus(1, 32'hAAAA_0004, 0, 0, 32'h0, 0, 0, 0);
        tick();
        applyStimulus(0, 32'h0, 0, 0, 32'h0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall instr", instr, 32'hAAAA_0004);
            checkOutput("stall pc", instr_pc, 32'h4);
            checkOutput("stall valid", {31'd0, instr_valid}, 32'd1);
            checkOutput("stall req", {31'd0, imem_req}, 32'd0);
            checkOutput("stall count", fetch_count, 32'd1);
            tick();
        end
        applyStimulus(0, 32'h0, 1, 0, 32'h0, 0, 0, 0);
        tick();
        applyStimulus(0, 32'h0, 0, 0, 32'h0, 0, 0, 0);
        checkOutput("fetch2 addr", imem_addr, 32'h8);
        checkOutput("fetch2 count", fetch_count, 32'd2);

        // Redirect while fetch of 8 outstanding: drain then refetch at 0x100
        applyStimulus(0, 32'h0, 0, 1, 32'h100, 0, 0, 0);
        tick();
        applyStimulus(0, 32'h0, 0, 0, 32'h0, 0, 0, 0);
        checkOutput("drain req", {31'd0, imem_req}, 32'd1);
        checkOutput("drain addr", imem_addr, 32'h8);
        tick();
        checkOutput("drain addr2", imem_addr, 32'h8);
        applyStimulus(1, 32'hDEAD_BEEF, 1, 0, 32'h0, 0, 0, 0);
        tick();
        applyStimulus(0, 32'h0, 0, 0, 32'h0, 0, 0, 0);
        checkOutput("post drain addr", imem_addr, 32'h100);
        checkOutput("post drain valid", {31'd0, instr_valid}, 32'd0);
        checkOutput("post drain count", fetch_count, 32'd2);

        // Redirect in HOLD: word dropped, no transfer counted
        applyStimulus(1, 32'hBBBB_0100, 0, 0, 32'h0, 0, 0, 0);
        tick();
        checkOutput("hold100 pc", instr_pc, 32'h100);
        applyStimulus(0, 32'h0, 1, 1, 32'h20, 0, 0, 0);
        tick();
        applyStimulus(0, 32'h0, 0, 0, 32'h0, 0, 0, 0);
        checkOutput("hold redir addr", imem_addr, 32'h20);
        checkOutput("hold redir valid", {31'd0, instr_valid}, 32'd0);
        checkOutput("hold redir count", fetch_count, 32'd2);

        // debug_halt during FETCH of 0x20: drain, halt, resume at 0x20
        applyStimulus(0, 32'h0, 0, 0, 32'h0, 1, 0, 0);
        tick();
        applyStimulus(0, 32'h0, 0, 0, 32'h0, 0, 0, 0);
        checkOutput("halt drain req", {31'd0, imem_req}, 32'd1);
        checkOutput("halt drain halted", {31'd0, halted}, 32'd0);
        applyStimulus(1, 32'h1111_1111, 0, 0, 32'h0, 0, 0, 0);
        tick();
        applyStimulus(0, 32'h0, 0, 0, 32'h0, 0, 0, 0);
        checkOutput("halt halted", {31'd0, halted}, 32'd1);
        checkOutput("halt req", {31'd0, imem_req}, 32'd0);
        checkOutput("halt valid", {31'd0, instr_valid}, 32'd0);
        tick();
        checkOutput("halt stays", {31'd0, halted}, 32'd1);
        applyStimulus(0, 32'h0, 0, 0, 32'h0, 0, 0, 1);
        tick();
        applyStimulus(0, 32'h0, 0, 0, 32'h0, 0, 0, 0);
        checkOutput("resume addr", imem_addr, 32'h20);
        checkOutput("resume req", {31'd0, imem_req}, 32'd1);
        checkOutput("resume halted", {31'd0, halted}, 32'd0);

        // debug_halt in HOLD, redirect while halted, resume at new pc
        applyStimulus(1, 32'hCCCC_0020, 0, 0, 32'h0, 0, 0, 0);
        tick();
        checkOutput("hold20 pc", instr_pc, 32'h20);
        applyStimulus(0, 32'h0, 0, 0, 32'h0, 1, 0, 0);
        tick();
        applyStimulus(0, 32'h0, 0, 0, 32'h0, 0, 0, 0);
        checkOutput("hold halt halted", {31'd0, halted}, 32'd1);
        checkOutput("hold halt valid", {31'd0, instr_valid}, 32'd0);
        applyStimulus(0, 32'h0, 0, 1, 32'h40, 0, 0, 0);
        tick();
        applyStimulus(0, 32'h0, 0, 0, 32'h0, 0, 0, 1);
        tick();
        applyStimulus(0, 32'h0, 0, 0, 32'h0, 0, 0, 0);
        checkOutput("resume40 addr", imem_addr, 32'h40);

        // Watchdog: no ack, TIMEOUT = 4 wait cycles
        tick();
        tick();
        tick();
        checkOutput("wd pre failed", {31'd0, failed}, 32'd0);
        checkOutput("wd pre req", {31'd0, imem_req}, 32'd1);
        tick();
        checkOutput("wd failed", {31'd0, failed}, 32'd1);
        checkOutput("wd req", {31'd0, imem_req}, 32'd0);
        applyStimulus(1, 32'h0, 1, 0, 32'h0, 0, 0, 1);
        tick();
        applyStimulus(0, 32'h0, 0, 0, 32'h0, 0, 0, 0);
        checkOutput("fail terminal", {31'd0, failed}, 32'd1);
        checkOutput("fail no valid", {31'd0, instr_valid}, 32'd0);

        // Reset out of FAIL, then misaligned redirect
        rst_n = 1'b0;
        #1;
        checkReset("reset2");
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("restart addr", imem_addr, 32'h0);
        applyStimulus(0, 32'h0, 0, 1, 32'h102, 0, 0, 0);
        tick();
        applyStimulus(0, 32'h0, 0, 0, 32'h0, 0, 0, 0);
        checkOutput("misalign failed", {31'd0, failed}, 32'd1);
        checkOutput("misalign req", {31'd0, imem_req}, 32'd0);

        // Reset during DRAIN abandons the request
        rst_n = 1'b0;
        #1;
        tick();
        rst_n = 1'b1;
        tick();
        applyStimulus(0, 32'h0, 0, 1, 32'h80, 0, 0, 0);
        tick();
        applyStimulus(1, 32'h5555_5555, 0, 0, 32'h0, 0, 0, 0);
        checkOutput("drain2 addr", imem_addr, 32'h0);
        checkOutput("drain2 req", {31'd0, imem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkReset("reset drain");
        tick();
        rst_n = 1'b1;
        tick();
        applyStimulus(0, 32'h0, 0, 0, 32'h0, 0, 0, 0);
        checkOutput("post rst addr", imem_addr, 32'h0);
        checkOutput("post rst req", {31'd0, imem_req}, 32'd1);
        checkOutput("post rst valid", {31'd0, instr_valid}, 32'd0);
        applyStimulus(1, 32'h7777_0000, 1, 0, 32'h0, 0, 0, 0);
        tick();
        applyStimulus(0, 32'h0, 1, 0, 32'h0, 0, 0, 0);
        checkOutput("post rst instr", instr, 32'h7777_0000);
        checkOutput("post rst pc", instr_pc, 32'h0);
        tick();
        applyStimulus(0, 32'h0, 0, 0, 32'h0, 0, 0, 0);
        checkOutput("post rst next addr", imem_addr, 32'h4);
        checkOutput("post rst count", fetch_count, 32'd1);

        // debug_fail pulse forces FAIL
        applyStimulus(0, 32'h0, 0, 0, 32'h0, 0, 1, 0);
        tick();
        applyStimulus(0, 32'h0, 0, 0, 32'h0, 0, 0, 0);
        checkOutput("dbg fail failed", {31'd0, failed}, 32'd1);
        checkOutput("dbg fail req", {31'd0, imem_req}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assert_count, fail_count);
        $finish;
    end

endmodule
